// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-latency single-port memory arbiter, DM priority with IF starvation guard; ports: clk/rst, if_* fetch, dm_* data, mem_* memory, busy
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [1:0]        state;
  logic [SW-1:0]     starve;
  logic [CW-1:0]     wcnt;
  logic              own_dm, cap_we, dm_win;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  assign dm_win    = dm_req && (!if_req || starve < SW'(STARVE_MAX));
  assign busy      = state != IDLE;
  assign if_gnt    = busy && !own_dm;
  assign dm_gnt    = busy && own_dm;
  assign mem_en    = state == ISSUE;
  assign mem_we    = mem_en && cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign if_done   = state == DONE && !own_dm;
  assign dm_done   = state == DONE && own_dm;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      starve    <= '0;
      wcnt      <= '0;
      own_dm    <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else
      case (state)
        IDLE:
          if (dm_req || if_req) begin
            state     <= ISSUE;
            own_dm    <= dm_win;
            cap_we    <= dm_win && dm_we;
            cap_addr  <= dm_win ? dm_addr : if_addr;
            cap_wdata <= dm_win ? dm_wdata : '0;
            starve    <= dm_win ? starve + SW'(if_req) : '0;
          end
        ISSUE: begin
          state <= cap_we ? DONE : WAIT;
          wcnt  <= CW'(MEM_LAT - 1);
        end
        WAIT:
          if (wcnt == '0) begin
            state <= DONE;
            if (own_dm) dm_rdata <= mem_rdata;
            else if_rdata <= mem_rdata;
          end else wcnt <= wcnt - CW'(1);
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (MEM_LAT=2/STARVE_MAX=2 and MEM_LAT=1 instances)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        a_if_req = 0, a_dm_req = 0, a_dm_we = 0;
  logic [31:0] a_if_addr = 0, a_dm_addr = 0, a_dm_wdata = 0;
  logic        a_if_gnt, a_if_done, a_dm_gnt, a_dm_done, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_req = 0, b_dm_req = 0, b_dm_we = 0;
  logic [31:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0;
  logic        b_if_gnt, b_if_done, b_dm_gnt, b_dm_done, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_done(a_if_done), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_done(a_dm_done), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy));
  // memory models: data is only valid exactly MEM_LAT cycles after mem_en, poison otherwise
  logic [31:0] rd_val = 0, b_rd_val = 0;
  logic        a_p0 = 0, a_p1 = 0, b_p0 = 0;
  logic [31:0] a_d0 = 0, a_d1 = 0, b_d0 = 0;
  always @(posedge clk) begin
    a_p0 <= a_mem_en;
    a_d0 <= rd_val;
    a_p1 <= a_p0;
    a_d1 <= a_d0;
    b_p0 <= b_mem_en;
    b_d0 <= b_rd_val;
  end
  assign a_mem_rdata = a_p1 ? a_d1 : 32'hBAD0_BAD0;
  assign b_mem_rdata = b_p0 ? b_d0 : 32'hBAD1_BAD1;
  typedef struct {int owner; logic [31:0] rdata; bit chk_data; int lat;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int owner, input logic [31:0] rdata, input bit chk_data, input int lat);
    exp_t e;
    e.owner = owner; e.rdata = rdata; e.chk_data = chk_data; e.lat = lat;
    q.push_back(e);
  endtask
  // owner codes: 0 = IF on dut_a, 1 = DM on dut_a, 2 = IF on dut_b, 3 = nothing finished
  task automatic wait_done(input int n0);
    int n, owner;
    logic [31:0] rdata;
    exp_t e;
    n = n0;
    do begin
      step();
      n++;
      chk("gnt_excl", {a_if_gnt, a_dm_gnt} == 2'b11, 0);
    end while (!(a_if_done || a_dm_done || b_if_done) && n < 30);
    owner = b_if_done ? 2 : a_dm_done ? 1 : a_if_done ? 0 : 3;
    rdata = owner == 2 ? b_if_rdata : owner == 1 ? a_dm_rdata : a_if_rdata;
    chk("sb_nonempty", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("done_owner", owner, e.owner);
      chk("done_latency", n, e.lat);
      if (e.chk_data) chk("done_rdata", rdata, e.rdata);
    end
  endtask
  initial begin
    step();
    step();
    chk("reset_outs", {a_busy, a_if_gnt, a_dm_gnt, a_if_done, a_dm_done, a_mem_en, a_mem_we}, 0);
    chk("reset_mem_addr", a_mem_addr, 0);
    rst = 0;
    step();
    // fetch on MEM_LAT=2
    a_if_req = 1; a_if_addr = 32'h10; rd_val = 32'hA5A5_0001;
    push(0, 32'hA5A5_0001, 1, 4);
    step();
    chk("t1_mem_en", a_mem_en, 1);
    chk("t1_mem_addr", a_mem_addr, 32'h10);
    chk("t1_mem_we", a_mem_we, 0);
    chk("t1_if_gnt", a_if_gnt, 1);
    wait_done(1);
    a_if_req = 0;
    step();
    chk("t1_busy_c5", a_busy, 0);
    // store: no WAIT, done in cycle 2
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h40; a_dm_wdata = 32'hDEADBEEF;
    push(1, 0, 0, 2);
    step();
    chk("t2_mem_en", a_mem_en, 1);
    chk("t2_mem_we", a_mem_we, 1);
    chk("t2_mem_addr", a_mem_addr, 32'h40);
    chk("t2_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    chk("t2_gnts", {a_dm_gnt, a_if_gnt}, 2'b10);
    a_dm_wdata = 32'h0;
    wait_done(1);
    a_dm_req = 0; a_dm_we = 0;
    step();
    // both held: STARVE_MAX=2 gives DM, DM, IF, DM, DM, IF
    a_dm_addr = 32'h100; a_if_addr = 32'h200; rd_val = 32'h5A5A_0000;
    a_dm_req = 1; a_if_req = 1;
    push(1, 32'h5A5A_0000, 1, 4);
    push(1, 32'h5A5A_0000, 1, 5);
    push(0, 32'h5A5A_0000, 1, 5);
    push(1, 32'h5A5A_0000, 1, 5);
    push(1, 32'h5A5A_0000, 1, 5);
    push(0, 32'h5A5A_0000, 1, 5);
    for (int i = 0; i < 6; i++) wait_done(0);
    a_dm_req = 0; a_if_req = 0;
    step();
    step();
    // reset during WAIT of a fetch abandons it
    a_if_req = 1; a_if_addr = 32'h20; rd_val = 32'h1111;
    step();
    step();
    chk("t4_in_wait", {a_busy, a_mem_en}, 2'b10);
    #1 rst = 1;
    #1;
    chk("t4_async_outs", {a_busy, a_if_gnt, a_dm_gnt, a_if_done, a_dm_done, a_mem_en, a_mem_we}, 0);
    chk("t4_async_addr", a_mem_addr, 0);
    chk("t4_async_rdata", a_if_rdata, 0);
    step();
    chk("t4_no_done", a_if_done, 0);
    rst = 0; rd_val = 32'h2222;
    push(0, 32'h2222, 1, 4);
    wait_done(0);
    a_if_req = 0;
    step();
    // dm_req dropped in WAIT still completes
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h80; rd_val = 32'h1234;
    push(1, 32'h1234, 1, 4);
    step();
    chk("t5_mem_addr", a_mem_addr, 32'h80);
    step();
    a_dm_req = 0; a_dm_addr = 32'h0;
    wait_done(2);
    step();
    chk("t5_idle1", a_busy, 0);
    step();
    chk("t5_idle2", {a_busy, a_mem_en}, 0);
    // MEM_LAT=1 fetch on dut_b
    b_if_req = 1; b_if_addr = 32'h30; b_rd_val = 32'hC0DE_0003;
    push(2, 32'hC0DE_0003, 1, 3);
    step();
    chk("t6_mem_en", b_mem_en, 1);
    chk("t6_mem_addr", b_mem_addr, 32'h30);
    step();
    chk("t6_wait", {b_busy, b_mem_en, b_if_done}, 3'b100);
    wait_done(2);
    b_if_req = 0;
    step();
    chk("t6_idle", b_busy, 0);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
